card_match_ctrl: RTL and testbench
==================================

# card_match_ctrl

Turn and pair-matching controller for the 16-card memory game. It consumes the card selections produced by the cursor/move block (a card index plus a one-cycle select strobe) and reveals the selected cards. It compares each revealed pair, keeps matched pairs up and flips mismatched pairs down after a display delay, and tracks two players' scores and turns until all 8 pairs are found.

## Interface
- SHOW_CYCLES, 25_000_000: cycles a revealed pair stays face-up before it resolves; must be ≥ 1.
- TIMEOUT_CYCLES, 500_000_000: idle cycles before the turn is forfeited (used only with the timeout feature).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- sel_valid  in  1  one-cycle select strobe from the cursor block.
- sel_idx  in  4  index (0–15) of the card under the cursor; sampled only when sel_valid=1.
- sym  in  64  deck contents; the symbol of card i is sym[4i+3:4i]; held stable during play.
- face_up  out  16  bit i=1: card i is currently revealed but not yet matched.
- matched  out  16  bit i=1: card i belongs to a found pair.
- player  out  1  player whose turn it is (0 or 1).
- score0, score1  out  4 each  pairs found by each player (0–8).
- busy  out  1  1 while a pair is being shown; selections are rejected.
- reject  out  1  one-cycle pulse when a strobe is ignored.
- timeout  out  1  one-cycle pulse when a turn is forfeited.
- game_over  out  1  1 when all 16 cards are matched.
- winner  out  2  01 = player 0, 10 = player 1, 11 = tie; 00 until game_over.

## Operation
- States: FIRST (waiting for the first card), SECOND (waiting for the second card), SHOW (pair displayed), DONE.
- Reset values:
  - All outputs are 0.
  - State is FIRST, all timers are 0, and the stored first index is 0.
- Accepting a strobe in FIRST:
  - Requires face_up[sel_idx]=0 and matched[sel_idx]=0.
  - Sets face_up[sel_idx], stores the index, and moves to SECOND.
- Accepting a strobe in SECOND:
  - Requires the same validity conditions as in FIRST.
  - Sets face_up[sel_idx] and registers the match flag (sym of the first card == sym of the second card).
  - Loads the show timer with SHOW_CYCLES-1 and moves to SHOW.
- Rejected strobes:
  - A strobe in SHOW or DONE is ignored, as is a strobe on a face-up or matched card (including re-selecting the first card).
  - Each rejected strobe pulses reject for one cycle and changes no other state.
- SHOW behaviour:
  - The timer decrements each cycle.
  - On the edge where the timer is 0, the pair resolves:
    - Both face_up bits clear.
    - On a match, both matched bits set, the current player's score increments, and the same player continues.
    - On a mismatch, player toggles.
  - Next state is DONE if matched would become all-ones, otherwise FIRST.
- DONE: game_over=1 and winner is set from the score comparison. The block holds in DONE until reset.
- Arithmetic:
  - Scores are 4-bit and cannot exceed 8, because only 8 pairs exist.
  - The timer width is $clog2 of the largest cycle parameter.

## Timing
- face_up for an accepted card rises on the clock edge that samples the strobe, i.e. 1-cycle latency.
- The second card is visible for exactly SHOW_CYCLES cycles. The resolution registers (matched, score, player, state) all update on the same edge.
- busy is high for exactly the SHOW_CYCLES cycles spent in SHOW.
- A strobe arriving on the resolving edge is rejected; the first strobe that can be accepted is the one on the following edge.
- reject and timeout are registered pulses, one cycle wide.
- Reset asserted mid-game (any state) clears everything asynchronously; play restarts in FIRST with player 0.

## Configuration
- MATCH_TURN_TIMEOUT_EN defined:
  - An idle counter runs in FIRST and SECOND and clears on every accepted strobe and on every state entry.
  - After TIMEOUT_CYCLES consecutive cycles without an accepted strobe:
    - In SECOND, the first card's face_up bit clears.
    - player toggles, state goes to FIRST, and timeout pulses.
- MATCH_TURN_TIMEOUT_EN undefined: no idle counter is built, timeout is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
All scenarios use SHOW_CYCLES=4, TIMEOUT_CYCLES=20, and sym with cards 2k and 2k+1 both holding symbol k.
- Match: select 0 then 1 → face_up=0x0003 for 4 cycles; then matched=0x0003, score0=1, player stays 0.
- Mismatch: select 2 then 5 → face_up=0x0024 for 4 cycles; then face_up=0, matched unchanged, player=1.
- Rejects: select 3 twice, then select during SHOW, then select a matched card → reject pulses each time, with no change to face_up, matched, score or player.
- Full game: player 0 matches all 8 pairs in order → game_over=1, score0=8, winner=01; further strobes pulse reject.
- Reset mid-SHOW: assert rst for 1 cycle → all outputs 0; selecting 0 then 1 afterwards still gives score0=1.
- Timeout (with MATCH_TURN_TIMEOUT_EN): select card 4, then idle 20 cycles → face_up=0, player=1, timeout pulses once.

Source files
------------

// File: rtl/card_match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : card_match_ctrl_if
// Description : Selection inputs and game-status outputs of card_match_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface card_match_ctrl_if;
    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic [63:0] sym;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic        reject;
    logic        timeout;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output sel_valid, sel_idx, sym,
        input  face_up, matched, player, score0, score1,
        input  busy, reject, timeout, game_over, winner
    );

    modport slave (
        input  sel_valid, sel_idx, sym,
        output face_up, matched, player, score0, score1,
        output busy, reject, timeout, game_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/card_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : card_match_ctrl
// Description : Turn and pair-matching controller for a 16-card memory game.
//               Optional turn timeout enabled by MATCH_TURN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module card_match_ctrl #(
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    card_match_ctrl_if.slave  bus
);

    localparam int c_MAX_CYC = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TW      = ($clog2(c_MAX_CYC) < 1) ? 1 : $clog2(c_MAX_CYC);

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_SHOW   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            r_state, w_state_nx;
    logic [15:0]       r_face_up, w_face_nx;
    logic [15:0]       r_matched, w_matched_nx;
    logic              r_player, w_player_nx;
    logic [3:0]        r_score0, w_score0_nx;
    logic [3:0]        r_score1, w_score1_nx;
    logic [3:0]        r_first_idx, w_first_nx;
    logic [3:0]        r_second_idx, w_second_nx;
    logic              r_match, w_match_nx;
    logic [c_TW-1:0]   r_timer, w_timer_nx;
    logic              r_reject, w_reject_nx;
    logic              w_sel_ok;
    logic              w_accept;
    logic [3:0]        w_sym_sel;
    logic [3:0]        w_sym_first;
    logic [1:0]        w_winner;
`ifdef MATCH_TURN_TIMEOUT_EN
    logic [c_TW-1:0]   r_idle, w_idle_nx;
    logic              r_timeout, w_timeout_nx;
`endif

    assign w_sel_ok    = bus.sel_valid && !r_face_up[bus.sel_idx] && !r_matched[bus.sel_idx];
    assign w_accept    = w_sel_ok && ((r_state == ST_FIRST) || (r_state == ST_SECOND));
    assign w_sym_sel   = bus.sym[{bus.sel_idx, 2'b00} +: 4];
    assign w_sym_first = bus.sym[{r_first_idx, 2'b00} +: 4];

    always_comb begin
        w_state_nx   = r_state;
        w_face_nx    = r_face_up;
        w_matched_nx = r_matched;
        w_player_nx  = r_player;
        w_score0_nx  = r_score0;
        w_score1_nx  = r_score1;
        w_first_nx   = r_first_idx;
        w_second_nx  = r_second_idx;
        w_match_nx   = r_match;
        w_timer_nx   = r_timer;
        w_reject_nx  = bus.sel_valid && !w_accept;
`ifdef MATCH_TURN_TIMEOUT_EN
        w_idle_nx    = '0;
        w_timeout_nx = 1'b0;
`endif

        case (r_state)
            ST_FIRST: begin
                if (w_accept) begin
                    w_face_nx[bus.sel_idx] = 1'b1;
                    w_first_nx             = bus.sel_idx;
                    w_state_nx             = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (w_accept) begin
                    w_face_nx[bus.sel_idx] = 1'b1;
                    w_second_nx            = bus.sel_idx;
                    w_match_nx             = (w_sym_sel == w_sym_first);
                    w_timer_nx             = c_TW'(SHOW_CYCLES - 1);
                    w_state_nx             = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_timer == '0) begin
                    w_face_nx = '0;
                    if (r_match) begin
                        w_matched_nx[r_first_idx]  = 1'b1;
                        w_matched_nx[r_second_idx] = 1'b1;
                        if (r_player) w_score1_nx = r_score1 + 4'd1;
                        else          w_score0_nx = r_score0 + 4'd1;
                    end else begin
                        w_player_nx = ~r_player;
                    end
                    w_state_nx = (&w_matched_nx) ? ST_DONE : ST_FIRST;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            default: ;
        endcase

`ifdef MATCH_TURN_TIMEOUT_EN
        // Idle time only accrues while a selection is awaited; any accepted
        // strobe or state change restarts it from zero.
        if (((r_state == ST_FIRST) || (r_state == ST_SECOND)) && !w_accept) begin
            if (r_idle == c_TW'(TIMEOUT_CYCLES - 1)) begin
                if (r_state == ST_SECOND) w_face_nx[r_first_idx] = 1'b0;
                w_player_nx  = ~r_player;
                w_state_nx   = ST_FIRST;
                w_timeout_nx = 1'b1;
            end else begin
                w_idle_nx = r_idle + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FIRST;
            r_face_up    <= '0;
            r_matched    <= '0;
            r_player     <= 1'b0;
            r_score0     <= '0;
            r_score1     <= '0;
            r_first_idx  <= '0;
            r_second_idx <= '0;
            r_match      <= 1'b0;
            r_timer      <= '0;
            r_reject     <= 1'b0;
`ifdef MATCH_TURN_TIMEOUT_EN
            r_idle       <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_face_up    <= w_face_nx;
            r_matched    <= w_matched_nx;
            r_player     <= w_player_nx;
            r_score0     <= w_score0_nx;
            r_score1     <= w_score1_nx;
            r_first_idx  <= w_first_nx;
            r_second_idx <= w_second_nx;
            r_match      <= w_match_nx;
            r_timer      <= w_timer_nx;
            r_reject     <= w_reject_nx;
`ifdef MATCH_TURN_TIMEOUT_EN
            r_idle       <= w_idle_nx;
            r_timeout    <= w_timeout_nx;
`endif
        end
    end

    always_comb begin
        w_winner = 2'b00;
        if (r_state == ST_DONE) begin
            if (r_score0 > r_score1)      w_winner = 2'b01;
            else if (r_score1 > r_score0) w_winner = 2'b10;
            else                          w_winner = 2'b11;
        end
    end

    assign bus.face_up   = r_face_up;
    assign bus.matched   = r_matched;
    assign bus.player    = r_player;
    assign bus.score0    = r_score0;
    assign bus.score1    = r_score1;
    assign bus.busy      = (r_state == ST_SHOW);
    assign bus.reject    = r_reject;
    assign bus.game_over = (r_state == ST_DONE);
    assign bus.winner    = w_winner;
`ifdef MATCH_TURN_TIMEOUT_EN
    assign bus.timeout   = r_timeout;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_card_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_match_ctrl
// Description : Directed self-checking bench for card_match_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_match_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    card_match_ctrl_if bus ();

    card_match_ctrl #(
        .SHOW_CYCLES    (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one strobe starting at a falling edge; returns at the next falling edge.
    task automatic sel(input logic [3:0] idx);
        bus.sel_valid = 1'b1;
        bus.sel_idx   = idx;
        @(negedge clk);
        bus.sel_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, bus.busy}, 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return {17'd0, bus.face_up, bus.matched, bus.player, bus.score0, bus.score1,
                bus.busy, bus.reject, bus.timeout, bus.game_over, bus.winner};
    endfunction

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.sel_valid = 1'b0;
        bus.sel_idx   = 4'd0;
        bus.sym       = 64'h7766_5544_3322_1100;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Match 0/1 by player 0
        sel(4'd0);
        chk("match_first_face", {48'd0, bus.face_up}, 64'h0001);
        chk("match_first_busy", {63'd0, bus.busy}, 64'd0);
        sel(4'd1);
        chk("match_show_face", {48'd0, bus.face_up}, 64'h0003);
        chk("match_show_busy", {63'd0, bus.busy}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("match_show_hold", {47'd0, bus.busy, bus.face_up}, {47'd1, 16'h0003});
        end
        @(negedge clk);
        chk("match_resolved", {23'd0, bus.busy, bus.face_up, bus.matched, bus.player, bus.score0},
            {23'd0, 1'b0, 16'h0000, 16'h0003, 1'b0, 4'd1});

        // Mismatch 2/5
        sel(4'd2);
        chk("mis_first_face", {48'd0, bus.face_up}, 64'h0004);
        sel(4'd5);
        chk("mis_show_face", {48'd0, bus.face_up}, 64'h0024);
        wait_idle("mis_busy_bound");
        chk("mis_resolved", {23'd0, bus.face_up, bus.matched, bus.player, bus.score0, bus.score1},
            {23'd0, 16'h0000, 16'h0003, 1'b1, 4'd1, 4'd0});

        // Rejects (player 1 to move)
        sel(4'd3);
        chk("rej_first_face", {48'd0, bus.face_up}, 64'h0008);
        sel(4'd3);
        chk("rej_reselect", {46'd0, bus.reject, bus.busy, bus.face_up}, {46'd0, 1'b1, 1'b0, 16'h0008});
        sel(4'd6);
        chk("rej_second_accept", {46'd0, bus.reject, bus.busy, bus.face_up}, {46'd0, 1'b0, 1'b1, 16'h0048});
        sel(4'd7);
        chk("rej_during_show", {47'd0, bus.reject, bus.face_up}, {47'd1, 16'h0048});
        @(negedge clk);
        chk("rej_pulse_width", {63'd0, bus.reject}, 64'd0);
        wait_idle("rej_busy_bound");
        chk("rej_mismatch_player", {47'd0, bus.player, bus.face_up}, {47'd0, 16'h0000});
        sel(4'd0);
        chk("rej_matched_card", {21'd0, bus.reject, bus.face_up, bus.matched, bus.player, bus.score0, bus.score1},
            {21'd0, 1'b1, 16'h0000, 16'h0003, 1'b0, 4'd1, 4'd0});

        // Player 0 completes the remaining pairs
        for (int k = 1; k < 8; k++) begin
            sel(4'(2 * k));
            sel(4'(2 * k + 1));
            wait_idle("game_busy_bound");
        end
        chk("game_over_state", {37'd0, bus.game_over, bus.winner, bus.matched, bus.score0, bus.score1, bus.player},
            {37'd0, 1'b1, 2'b01, 16'hFFFF, 4'd8, 4'd0, 1'b0});
        sel(4'd4);
        chk("game_over_reject", {44'd0, bus.reject, bus.game_over, bus.winner, bus.matched},
            {44'd0, 1'b1, 1'b1, 2'b01, 16'hFFFF});

        // Fresh game, then reset while a pair is showing
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel(4'd0);
        sel(4'd2);
        chk("rst_pre_busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_show", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel(4'd0);
        sel(4'd1);
        wait_idle("rst_busy_bound");
        chk("rst_replay", {27'd0, bus.matched, bus.player, bus.score0, bus.score1, bus.face_up},
            {27'd0, 16'h0003, 1'b0, 4'd1, 4'd0, 16'h0000});

`ifdef MATCH_TURN_TIMEOUT_EN
        sel(4'd4);
        for (int i = 0; i < 19; i++) @(negedge clk);
        chk("to_before", {46'd0, bus.timeout, bus.player, bus.face_up}, {46'd0, 1'b0, 1'b0, 16'h0010});
        @(negedge clk);
        chk("to_fire", {46'd0, bus.timeout, bus.player, bus.face_up}, {46'd0, 1'b1, 1'b1, 16'h0000});
        @(negedge clk);
        chk("to_pulse_width", {63'd0, bus.timeout}, 64'd0);
`else
        sel(4'd4);
        for (int i = 0; i < 25; i++) @(negedge clk);
        chk("to_disabled", {46'd0, bus.timeout, bus.player, bus.face_up}, {46'd0, 1'b0, 1'b0, 16'h0010});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
        $fatal(1);
    end

endmodule
`default_nettype wire
